// File: rtl/difftest_arch_event_queue_pkg.sv
// Shared types for the multi-core difftest architectural-event queue.
// The event record carries its source core id so one stream can serve all cores.
package difftest_pkg;

  localparam int DIFFTEST_PC_W = 64;

  typedef struct packed {
    logic [31:0]              interrupt;
    logic [31:0]              exception;
    logic [DIFFTEST_PC_W-1:0] exceptionPC;
    logic [31:0]              exceptionInst;
    logic [7:0]               coreid;
  } arch_event_t;

  // Core id of a channel; deliberately wraps modulo 256.
  function automatic logic [7:0] coreid_of(input int base, input int idx);
    int sum;
    sum = base + idx;
    return sum[7:0];
  endfunction

endpackage

// File: rtl/difftest_arch_event_queue_if.sv
// Output event stream of the queue: valid/ready handshake plus head fields.
// master drives the event, slave (the monitor) drives ready.
interface difftest_arch_event_queue_if;
  import difftest_pkg::*;

  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_interrupt;
  logic [31:0]              out_exception;
  logic [DIFFTEST_PC_W-1:0] out_exceptionPC;
  logic [31:0]              out_exceptionInst;
  logic [7:0]               out_coreid;

  modport master (
    output out_valid, out_interrupt, out_exception, out_exceptionPC,
           out_exceptionInst, out_coreid,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_interrupt, out_exception, out_exceptionPC,
           out_exceptionInst, out_coreid,
    output out_ready
  );

endinterface

// File: rtl/difftest_arch_event_queue_fifo.sv
// Synchronous show-ahead FIFO of arch events with an entry count.
// Head entry is read combinationally so the consumer sees it the cycle after the push.
module difftest_event_fifo
  import difftest_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_push,
  input  arch_event_t            i_data,
  input  logic                   i_pop,
  output logic                   o_valid,
  output arch_event_t            o_data,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0]   ONE_CNT  = 1;
  localparam logic [AW-1:0] ONE_PTR  = 1;

  arch_event_t     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == FULL_CNT);
  assign w_pop   = i_pop && o_valid;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ONE_PTR;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ONE_PTR;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_CNT;
        2'b01:   r_count <= r_count - ONE_CNT;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/difftest_arch_event_queue.sv
// Captures interrupt/exception events from NUM_CORES commit channels into per-channel
// pending registers, merges them round-robin into one shared FIFO, and counts losses.
module difftest_arch_event_queue
  import difftest_pkg::*;
#(
  parameter int NUM_CORES      = 2,
  parameter int DEPTH          = 8,
  parameter int PC_WIDTH       = 64,
  parameter int CORE_BASE      = 0,
  parameter bit FILTER_EMPTY   = 1'b1,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_CORES-1:0]          io_valid,
  input  logic [32*NUM_CORES-1:0]       io_interrupt,
  input  logic [32*NUM_CORES-1:0]       io_exception,
  input  logic [PC_WIDTH*NUM_CORES-1:0] io_exceptionPC,
  input  logic [32*NUM_CORES-1:0]       io_exceptionInst,
  difftest_arch_event_queue_if.master   o_evt,
  output logic [$clog2(DEPTH):0]        occupancy,
  output logic                          overflow,
  output logic [DROP_CNT_WIDTH-1:0]     drop_count
);

  localparam int RR_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_EXT_W = DROP_CNT_WIDTH + 5;
  localparam logic [CNT_EXT_W-1:0] DROP_MAX = {{5{1'b0}}, {DROP_CNT_WIDTH{1'b1}}};
  localparam logic [RR_W-1:0]      RR_LAST  = RR_W'(NUM_CORES - 1);
  localparam logic [RR_W-1:0]      RR_ONE   = 1;

  arch_event_t                w_in_evt   [NUM_CORES];
  arch_event_t                r_pend_evt [NUM_CORES];
  logic [NUM_CORES-1:0]       r_pend_valid;
  logic [NUM_CORES-1:0]       w_pend_valid_next;
  logic [NUM_CORES-1:0]       w_cap;
  logic [NUM_CORES-1:0]       w_load;
  logic [NUM_CORES-1:0]       w_drop;
  logic [NUM_CORES-1:0]       w_grant;
  logic [RR_W-1:0]            r_rr;
  logic [RR_W-1:0]            w_rr_next;
  logic                       w_grant_any;
  logic [RR_W-1:0]            w_grant_idx;
  logic                       w_can_push;
  logic                       w_pop;
  logic                       w_fifo_valid;
  logic                       w_fifo_full;
  arch_event_t                w_push_evt;
  arch_event_t                w_head;
  logic [4:0]                 w_drop_n;
  logic [CNT_EXT_W-1:0]       w_drop_sum;
  logic [DROP_CNT_WIDTH-1:0]  w_drop_next;
  logic [DROP_CNT_WIDTH-1:0]  r_drop_count;
  logic                       r_overflow;

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_chan
    assign w_in_evt[gi] = {io_interrupt[32*gi +: 32],
                           io_exception[32*gi +: 32],
                           io_exceptionPC[PC_WIDTH*gi +: PC_WIDTH],
                           io_exceptionInst[32*gi +: 32],
                           coreid_of(CORE_BASE, gi)};
    assign w_cap[gi]   = enable && io_valid[gi] &&
                         (!FILTER_EMPTY || (|io_interrupt[32*gi +: 32]) ||
                          (|io_exception[32*gi +: 32]));
    assign w_grant[gi] = w_grant_any && (w_grant_idx == RR_W'(gi));
    // The granted slot is vacated this edge, so a fresh capture may refill it.
    assign w_load[gi]  = w_cap[gi] && (!r_pend_valid[gi] || w_grant[gi]);
    assign w_drop[gi]  = w_cap[gi] && r_pend_valid[gi] && !w_grant[gi];
  end

  assign w_pop      = o_evt.out_valid && o_evt.out_ready;
  assign w_can_push = !w_fifo_full || w_pop;

  // Round robin: lowest pending index at or above rr wins, else lowest overall.
  always_comb begin
    logic found_hi;
    logic found_any;
    logic [RR_W-1:0] idx_hi;
    logic [RR_W-1:0] idx_any;
    found_hi  = 1'b0;
    found_any = 1'b0;
    idx_hi    = '0;
    idx_any   = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!found_hi && r_pend_valid[i] && (RR_W'(i) >= r_rr)) begin
        found_hi = 1'b1;
        idx_hi   = RR_W'(i);
      end
      if (!found_any && r_pend_valid[i]) begin
        found_any = 1'b1;
        idx_any   = RR_W'(i);
      end
    end
    w_grant_any = found_any && w_can_push;
    w_grant_idx = found_hi ? idx_hi : idx_any;
    w_rr_next   = r_rr;
    if (w_grant_any) begin
      w_rr_next = (w_grant_idx == RR_LAST) ? '0 : w_grant_idx + RR_ONE;
    end
  end

  always_comb begin
    w_push_evt        = '0;
    w_pend_valid_next = r_pend_valid;
    w_drop_n          = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_grant[i]) begin
        w_push_evt = r_pend_evt[i];
      end
      if (w_load[i]) begin
        w_pend_valid_next[i] = 1'b1;
      end else if (w_grant[i]) begin
        w_pend_valid_next[i] = 1'b0;
      end
      w_drop_n = w_drop_n + {4'b0000, w_drop[i]};
    end
    w_drop_sum  = {5'b00000, r_drop_count} + {{(CNT_EXT_W-5){1'b0}}, w_drop_n};
    w_drop_next = (w_drop_sum > DROP_MAX) ? '1 : w_drop_sum[DROP_CNT_WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_load[i]) begin
        r_pend_evt[i] <= w_in_evt[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend_valid <= '0;
      r_rr         <= '0;
      r_drop_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_pend_valid <= w_pend_valid_next;
      r_rr         <= w_rr_next;
      r_drop_count <= w_drop_next;
      if (|w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  difftest_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_grant_any),
    .i_data  (w_push_evt),
    .i_pop   (w_pop),
    .o_valid (w_fifo_valid),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_count (occupancy)
  );

  // Nothing is presented while reset is held, even if entries are still stored.
  assign o_evt.out_valid         = w_fifo_valid && !reset;
  assign o_evt.out_interrupt     = w_head.interrupt;
  assign o_evt.out_exception     = w_head.exception;
  assign o_evt.out_exceptionPC   = w_head.exceptionPC;
  assign o_evt.out_exceptionInst = w_head.exceptionInst;
  assign o_evt.out_coreid        = w_head.coreid;

  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule
